// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter giving NUM_CONSUMERS four-phase read/write channels one shared memory port.
// Optional: define MEM_CHANNEL_ARBITER_TIMEOUT_EN to add a memory wait timeout and consumer_error output.
module mem_channel_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int NUM_CONSUMERS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
`ifdef MEM_CHANNEL_ARBITER_TIMEOUT_EN
  ,
  output logic [NUM_CONSUMERS-1:0]           consumer_error
`endif
);

  localparam int IDX_W = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic               served_read;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   idx;
  logic               found;
  logic [NUM_CONSUMERS-1:0] any_req;
  logic [IDX_W-1:0]   next_ptr;
  logic               served_valid;

`ifdef MEM_CHANNEL_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_count;
  logic             timed_out;
  assign timed_out = (wait_count == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign any_req      = consumer_read_valid | consumer_write_valid;
  assign next_ptr     = (grant == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant + 1'b1;
  assign served_valid = served_read ? consumer_read_valid[grant] : consumer_write_valid[grant];

  // First requesting consumer at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_CONSUMERS);
      if (!found && any_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant                <= '0;
      served_read          <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
`ifdef MEM_CHANNEL_ARBITER_TIMEOUT_EN
      wait_count           <= '0;
      consumer_error       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
`ifdef MEM_CHANNEL_ARBITER_TIMEOUT_EN
            wait_count <= '0;
`endif
            // A consumer with both valids is served read first.
            if (consumer_read_valid[pick]) begin
              served_read      <= 1'b1;
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
              state            <= READ_WAIT;
            end else begin
              served_read       <= 1'b0;
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[pick*DATA_BITS +: DATA_BITS];
              state             <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid                                 <= 1'b0;
            consumer_read_data[grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[grant]                     <= 1'b1;
            state                                          <= RELAY;
          end
`ifdef MEM_CHANNEL_ARBITER_TIMEOUT_EN
          else if (timed_out) begin
            mem_read_valid                                 <= 1'b0;
            consumer_read_data[grant*DATA_BITS +: DATA_BITS] <= '0;
            consumer_read_ready[grant]                     <= 1'b1;
            consumer_error[grant]                          <= 1'b1;
            state                                          <= RELAY;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
`endif
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
            state                       <= RELAY;
          end
`ifdef MEM_CHANNEL_ARBITER_TIMEOUT_EN
          else if (timed_out) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
            consumer_error[grant]       <= 1'b1;
            state                       <= RELAY;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
`endif
        end
        RELAY: begin
          if (!served_valid) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
`ifdef MEM_CHANNEL_ARBITER_TIMEOUT_EN
            consumer_error       <= '0;
`endif
            rr_ptr               <= next_ptr;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
